maq_bcd: RTL and testbench

- Parametrised two-digit BCD modulo counter; generalised successor of the fixed 00–59 minute counter in the clock datapath.
- One instance covers seconds (0–59), minutes (0–59), 24-hour hours (0–23) or 12-hour hours (1–12).
- Supports up/down counting and a parallel load for time-setting.
- Produces registered one-cycle carry and borrow pulses that chain into the next stage's count strobe.

---
 rtl/maq_pkg.sv | 29 ++
 rtl/maq_bcd_next.sv | 58 +++++
 rtl/maq_bcd.sv | 122 ++++++++++++
 tb/tb_maq_bcd.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/maq_pkg.sv
// Shared BCD types and helpers for the maq_bcd counter family.
package maq_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_MAX_DIGIT = 9;

  // Direction handed to the successor logic.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Two BCD digits to their decimal value.
  function automatic int bcd_to_int(input int msd, input int lsd);
    return 10 * msd + lsd;
  endfunction

  // Units digit of a decimal value (used for MIN_VAL/MAX_VAL constants).
  function automatic bcd_digit_t int_to_bcd_lsd(input int value);
    return bcd_digit_t'(value % 10);
  endfunction

  // Tens digit of a decimal value; the caller sizes it to MSD_W.
  function automatic int int_to_bcd_msd(input int value);
    return value / 10;
  endfunction

endpackage

// File: rtl/maq_bcd_next.sv
// Combinational successor/predecessor of a two-digit BCD value in
// [MIN_VAL, MAX_VAL], with a flag when the step wraps around the range.
module maq_bcd_next
  import maq_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int MSD_W   = 3
) (
  input  bcd_digit_t       i_lsd,
  input  logic [MSD_W-1:0] i_msd,
  input  dir_e             i_dir,
  output bcd_digit_t       o_lsd,
  output logic [MSD_W-1:0] o_msd,
  output logic             o_wrap
);

  localparam bcd_digit_t       MIN_LSD = int_to_bcd_lsd(MIN_VAL);
  localparam logic [MSD_W-1:0] MIN_MSD = MSD_W'(int_to_bcd_msd(MIN_VAL));
  localparam bcd_digit_t       MAX_LSD = int_to_bcd_lsd(MAX_VAL);
  localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(int_to_bcd_msd(MAX_VAL));

  int w_val;

  assign w_val = bcd_to_int(int'(i_msd), int'(i_lsd));

  // Step one count in the requested direction, wrapping at the range ends.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_lsd  = i_lsd;
    o_msd  = i_msd;
    o_wrap = 1'b0;
    if (i_dir == DIR_UP) begin
      if (w_val == MAX_VAL) begin
        o_lsd  = MIN_LSD;
        o_msd  = MIN_MSD;
        o_wrap = 1'b1;
      end else if (i_lsd < 4'(BCD_MAX_DIGIT)) begin
        o_lsd = i_lsd + 4'd1;
      end else begin
        o_lsd = 4'd0;
        o_msd = i_msd + MSD_W'(1);
      end
    end else begin
      if (w_val == MIN_VAL) begin
        o_lsd  = MAX_LSD;
        o_msd  = MAX_MSD;
        o_wrap = 1'b1;
      end else if (i_lsd != 4'd0) begin
        o_lsd = i_lsd - 4'd1;
      end else begin
        o_lsd = 4'(BCD_MAX_DIGIT);
        o_msd = i_msd - MSD_W'(1);
      end
    end
  end

endmodule

// File: rtl/maq_bcd.sv
// Parametrised two-digit BCD modulo counter with up/down count, parallel
// load and registered carry/borrow pulses for chaining stages.
// Optional build macro MAQBCD_LOADERR_EN adds a maqbcd_loaderr pulse output
// that flags each rejected load.
module maq_bcd
  import maq_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int MSD_W   = 3
) (
  input  logic             maqbcd_clock,
  input  logic             maqbcd_reset,
  input  logic             maqbcd_enable,
  input  logic             maqbcd_inc,
  input  logic             maqbcd_dec,
  input  logic             maqbcd_load,
  input  logic [3:0]       maqbcd_load_lsd,
  input  logic [MSD_W-1:0] maqbcd_load_msd,
  output logic [3:0]       maqbcd_lsd,
  output logic [MSD_W-1:0] maqbcd_msd,
  output logic             maqbcd_carry,
  output logic             maqbcd_borrow
`ifdef MAQBCD_LOADERR_EN
  ,
  output logic             maqbcd_loaderr
`endif
);

  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
    $error("maq_bcd: require 0 <= MIN_VAL < MAX_VAL <= 99");
  end
  if (MAX_VAL / 10 >= (1 << MSD_W)) begin : g_bad_msd_w
    $error("maq_bcd: MSD_W too narrow for the tens digit of MAX_VAL");
  end

  localparam bcd_digit_t       MIN_LSD = int_to_bcd_lsd(MIN_VAL);
  localparam logic [MSD_W-1:0] MIN_MSD = MSD_W'(int_to_bcd_msd(MIN_VAL));

  bcd_digit_t       r_lsd;
  logic [MSD_W-1:0] r_msd;
  logic             r_carry;
  logic             r_borrow;
`ifdef MAQBCD_LOADERR_EN
  logic             r_loaderr;
`endif

  logic             w_step;
  dir_e             w_dir;
  bcd_digit_t       w_next_lsd;
  logic [MSD_W-1:0] w_next_msd;
  logic             w_wrap;
  int               w_load_val;
  logic             w_load_ok;

  // inc and dec together cancel; enable gates counting but not loading.
  assign w_step = maqbcd_enable & (maqbcd_inc ^ maqbcd_dec);
  assign w_dir  = maqbcd_inc ? DIR_UP : DIR_DOWN;

  // A load is accepted only if it is a BCD units digit and lands inside the range.
  assign w_load_val = bcd_to_int(int'(maqbcd_load_msd), int'(maqbcd_load_lsd));
  assign w_load_ok  = (maqbcd_load_lsd <= 4'(BCD_MAX_DIGIT)) &&
                      (w_load_val >= MIN_VAL) && (w_load_val <= MAX_VAL);

  maq_bcd_next #(
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL),
    .MSD_W  (MSD_W)
  ) u_next (
    .i_lsd (r_lsd),
    .i_msd (r_msd),
    .i_dir (w_dir),
    .o_lsd (w_next_lsd),
    .o_msd (w_next_msd),
    .o_wrap(w_wrap)
  );

  // Digit and pulse registers: reset > load > count; pulses clear every non-wrap edge.
  always_ff @(posedge maqbcd_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (maqbcd_reset) begin
      r_lsd     <= MIN_LSD;
      r_msd     <= MIN_MSD;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
`ifdef MAQBCD_LOADERR_EN
      r_loaderr <= 1'b0;
`endif
    end else begin
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
`ifdef MAQBCD_LOADERR_EN
      r_loaderr <= 1'b0;
`endif
      if (maqbcd_load) begin
        if (w_load_ok) begin
          r_lsd <= maqbcd_load_lsd;
          r_msd <= maqbcd_load_msd;
        end
`ifdef MAQBCD_LOADERR_EN
        else begin
          r_loaderr <= 1'b1;
        end
`endif
      end else if (w_step) begin
        r_lsd    <= w_next_lsd;
        r_msd    <= w_next_msd;
        r_carry  <= w_wrap & (w_dir == DIR_UP);
        r_borrow <= w_wrap & (w_dir == DIR_DOWN);
      end
    end
  end

  assign maqbcd_lsd    = r_lsd;
  assign maqbcd_msd    = r_msd;
  assign maqbcd_carry  = r_carry;
  assign maqbcd_borrow = r_borrow;
`ifdef MAQBCD_LOADERR_EN
  assign maqbcd_loaderr = r_loaderr;
`endif

endmodule

// File: tb/tb_maq_bcd.sv
// Scoreboard bench for maq_bcd: three instances (00-59, 01-12, 00-23) share
// one stimulus stream; a decimal reference model predicts each edge and a
// separate monitor compares DUT outputs one step after every rising edge.
module tb_maq_bcd;

  typedef struct {
    int lsd;
    int msd;
    bit carry;
    bit borrow;
    bit loaderr;
  } exp_t;

  localparam int MINV [3] = '{0, 1, 0};
  localparam int MAXV [3] = '{59, 12, 23};
  localparam int MW   [3] = '{3, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       ld  = 1'b0;
  logic [3:0] ld_lsd = 4'd0;
  logic [3:0] ld_msd = 4'd0;

  logic [3:0] lsd_a, lsd_b, lsd_c;
  logic [2:0] msd_a;
  logic [0:0] msd_b;
  logic [1:0] msd_c;
  logic       carry_a, carry_b, carry_c;
  logic       borrow_a, borrow_b, borrow_c;
  logic       le_a, le_b, le_c;

  int   model_val [3];
  exp_t q_a [$];
  exp_t q_b [$];
  exp_t q_c [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  maq_bcd #(.MIN_VAL(0), .MAX_VAL(59), .MSD_W(3)) u_a (
    .maqbcd_clock(clk), .maqbcd_reset(rst), .maqbcd_enable(en),
    .maqbcd_inc(inc), .maqbcd_dec(dec), .maqbcd_load(ld),
    .maqbcd_load_lsd(ld_lsd), .maqbcd_load_msd(ld_msd[2:0]),
    .maqbcd_lsd(lsd_a), .maqbcd_msd(msd_a),
    .maqbcd_carry(carry_a), .maqbcd_borrow(borrow_a)
`ifdef MAQBCD_LOADERR_EN
    , .maqbcd_loaderr(le_a)
`endif
  );

  maq_bcd #(.MIN_VAL(1), .MAX_VAL(12), .MSD_W(1)) u_b (
    .maqbcd_clock(clk), .maqbcd_reset(rst), .maqbcd_enable(en),
    .maqbcd_inc(inc), .maqbcd_dec(dec), .maqbcd_load(ld),
    .maqbcd_load_lsd(ld_lsd), .maqbcd_load_msd(ld_msd[0:0]),
    .maqbcd_lsd(lsd_b), .maqbcd_msd(msd_b),
    .maqbcd_carry(carry_b), .maqbcd_borrow(borrow_b)
`ifdef MAQBCD_LOADERR_EN
    , .maqbcd_loaderr(le_b)
`endif
  );

  maq_bcd #(.MIN_VAL(0), .MAX_VAL(23), .MSD_W(2)) u_c (
    .maqbcd_clock(clk), .maqbcd_reset(rst), .maqbcd_enable(en),
    .maqbcd_inc(inc), .maqbcd_dec(dec), .maqbcd_load(ld),
    .maqbcd_load_lsd(ld_lsd), .maqbcd_load_msd(ld_msd[1:0]),
    .maqbcd_lsd(lsd_c), .maqbcd_msd(msd_c),
    .maqbcd_carry(carry_c), .maqbcd_borrow(borrow_c)
`ifdef MAQBCD_LOADERR_EN
    , .maqbcd_loaderr(le_c)
`endif
  );

`ifndef MAQBCD_LOADERR_EN
  assign le_a = 1'b0;
  assign le_b = 1'b0;
  assign le_c = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: counter value kept as a plain decimal integer.
  function automatic exp_t model(input int k, input bit r, input bit e, input bit up,
                                 input bit dn, input bit l, input int lsd, input int msd_raw);
    exp_t x;
    int   m;
    int   lv;
    x.carry   = 1'b0;
    x.borrow  = 1'b0;
    x.loaderr = 1'b0;
    m = msd_raw % (1 << MW[k]);
    if (r) begin
      model_val[k] = MINV[k];
    end else if (l) begin
      lv = 10 * m + lsd;
      if (lsd <= 9 && lv >= MINV[k] && lv <= MAXV[k]) model_val[k] = lv;
      else x.loaderr = 1'b1;
    end else if (e && (up != dn)) begin
      if (up) begin
        if (model_val[k] == MAXV[k]) begin model_val[k] = MINV[k]; x.carry = 1'b1; end
        else model_val[k] = model_val[k] + 1;
      end else begin
        if (model_val[k] == MINV[k]) begin model_val[k] = MAXV[k]; x.borrow = 1'b1; end
        else model_val[k] = model_val[k] - 1;
      end
    end
    x.lsd = model_val[k] % 10;
    x.msd = model_val[k] / 10;
    return x;
  endfunction

  // Apply one cycle of stimulus and queue the predicted response of each DUT.
  task automatic drive(input bit r, input bit e, input bit up, input bit dn,
                       input bit l, input int lsd, input int msd);
    @(negedge clk);
    rst = r; en = e; inc = up; dec = dn; ld = l;
    ld_lsd = 4'(lsd); ld_msd = 4'(msd);
    q_a.push_back(model(0, r, e, up, dn, l, lsd, msd));
    q_b.push_back(model(1, r, e, up, dn, l, lsd, msd));
    q_c.push_back(model(2, r, e, up, dn, l, lsd, msd));
  endtask

  task automatic compare(input string tag, input exp_t x, input logic [3:0] lsd,
                         input logic [3:0] msd, input logic c, input logic b, input logic le);
    check({tag, ".lsd"}, 32'(lsd), 32'(x.lsd));
    check({tag, ".msd"}, 32'(msd), 32'(x.msd));
    check({tag, ".carry"}, 32'(c), 32'(x.carry));
    check({tag, ".borrow"}, 32'(b), 32'(x.borrow));
`ifdef MAQBCD_LOADERR_EN
    check({tag, ".loaderr"}, 32'(le), 32'(x.loaderr));
`endif
  endtask

  // Monitor: after each rising edge, retire one prediction per DUT.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q_a.size() > 0) begin x = q_a.pop_front(); compare("A", x, lsd_a, 4'(msd_a), carry_a, borrow_a, le_a); end
    if (q_b.size() > 0) begin x = q_b.pop_front(); compare("B", x, lsd_b, 4'(msd_b), carry_b, borrow_b, le_b); end
    if (q_c.size() > 0) begin x = q_c.pop_front(); compare("C", x, lsd_c, 4'(msd_c), carry_c, borrow_c, le_c); end
  end

  initial begin
    // Reset, then a full 60-step up count (wraps B and C several times too).
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) drive(0, 1, 1, 0, 0, 0, 0);

    // Down from MIN_VAL wraps to MAX_VAL with borrow.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);

    // 20 -> 19 without borrow; 23 -> 00 with carry.
    drive(0, 1, 0, 0, 1, 0, 2);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 3, 2);
    drive(0, 1, 1, 0, 0, 0, 0);

    // Valid load, out-of-range load, non-BCD units digit.
    drive(0, 1, 0, 0, 1, 5, 4);
    drive(0, 1, 0, 0, 1, 0, 6);
    drive(0, 1, 0, 0, 1, 10, 0);
    drive(0, 1, 0, 0, 1, 15, 1);

    // From 59: load beats inc; inc+dec is a no-op; enable low freezes.
    drive(0, 1, 0, 0, 1, 9, 5);
    drive(0, 1, 1, 0, 1, 0, 1);
    drive(0, 1, 0, 0, 1, 9, 5);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 2, 1);

    // Reset mid-count with inc held, then counting resumes.
    drive(0, 1, 0, 0, 1, 7, 3);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      drive(sel == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            sel >= 90,
            (sel >= 97) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9)),
            int'($urandom_range(0, 7)));
    end

    // Drain the scoreboard with a bounded wait.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
